// File: rtl/mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// mem_stage_lsu
//
// RV32I MEM-stage load/store unit. Takes a decoded load/store from the
// EX/MEM register and runs one req/ack transaction on the data-memory port.
// It generates the byte enables and replicates the store data across lanes.
// For loads, it extracts and sign/zero-extends the returned lane and passes it
// to writeback together with rd. It stalls the upstream pipeline while the
// access is outstanding.
//
// Build option:
//   MISALIGN_TRAP_EN - when defined, a misaligned half or word access is
//                      rejected with access_err instead of being issued.
//                      When undefined, the low address bits that a half or
//                      word access does not use are ignored.
//
// Parameters:
//   ADDR_W   - width of addr / dmem_addr
//   MAX_WAIT - BUSY cycles without dmem_ack before a timeout error (0 = off)
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ex_valid, mem_read,   decoded instruction from EX/MEM
//   mem_write, inst_size,
//   load_unsigned, addr,
//   store_data, rd
//   stall                 hold EX/MEM and all upstream stages
//   wb_valid/wb_rd/wb_data one-cycle load result to writeback
//   access_err            one-cycle error pulse (illegal, misaligned, timeout)
//   dmem_*                data-memory request/ack port
// ---------------------------------------------------------------------------
module mem_stage_lsu #(
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        inst_size,
   input  logic              load_unsigned,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       store_data,
   input  logic [4:0]        rd,
   output logic              stall,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              access_err,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ack,
   input  logic [31:0]       dmem_rdata
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

   logic [0:0]        r_state;
   logic [CNT_W-1:0]  r_wait;
   logic              r_dmem_req;
   logic              r_dmem_we;
   logic [ADDR_W-1:0] r_dmem_addr;
   logic [3:0]        r_dmem_be;
   logic [31:0]       r_dmem_wdata;
   logic              r_is_load;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [1:0]        r_lane;
   logic [4:0]        r_rd;
   logic              r_wb_valid;
   logic [4:0]        r_wb_rd;
   logic [31:0]       r_wb_data;
   logic              r_err;

   logic              w_memop;
   logic              w_misalign;
   logic              w_reject;
   logic              w_timeout;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;

   // Selects the addressed lane and extends it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] d,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  lane,
                                                input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'b00:   b = d[7:0];
         2'b01:   b = d[15:8];
         2'b10:   b = d[23:16];
         default: b = d[31:24];
      endcase
      h = lane[1] ? d[31:16] : d[15:0];
      case (sz)
         2'b00:   load_extract = {{24{b[7] & ~uns}}, b};
         2'b01:   load_extract = {{16{h[15] & ~uns}}, h};
         default: load_extract = d;
      endcase
   endfunction

   assign w_memop = ex_valid & (mem_read | mem_write);

`ifdef MISALIGN_TRAP_EN
   assign w_misalign = ((inst_size == 2'b01) && addr[0]) ||
                       ((inst_size == 2'b10) && (addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_reject = (inst_size == 2'b11) | (mem_read & mem_write) | w_misalign;

   // Timeout fires in the last permitted BUSY cycle, so the instruction
   // leaves EX/MEM on the same edge an ack would have released it.
   assign w_timeout = (MAX_WAIT > 0) && (r_state == S_BUSY) && !dmem_ack &&
                      (r_wait == WAIT_LAST);

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = store_data;
      case (inst_size)
         2'b00: begin
            w_be    = 4'b0001 << addr[1:0];
            w_wdata = {4{store_data[7:0]}};
         end
         2'b01: begin
            w_be    = addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{store_data[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = store_data;
         end
      endcase
   end

   // Stall covers the accept cycle and every BUSY cycle still waiting.
   assign stall = !reset &&
                  (((r_state == S_IDLE) && w_memop && !w_reject) ||
                   ((r_state == S_BUSY) && !dmem_ack && !w_timeout));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_wait       <= '0;
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= '0;
         r_dmem_be    <= 4'b0000;
         r_dmem_wdata <= 32'h0;
         r_is_load    <= 1'b0;
         r_size       <= 2'b00;
         r_unsigned   <= 1'b0;
         r_lane       <= 2'b00;
         r_rd         <= 5'd0;
         r_wb_valid   <= 1'b0;
         r_wb_rd      <= 5'd0;
         r_wb_data    <= 32'h0;
         r_err        <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         r_err      <= 1'b0;
         if (r_state == S_IDLE) begin
            if (w_memop) begin
               if (w_reject) begin
                  r_err <= 1'b1;
               end else begin
                  r_state      <= S_BUSY;
                  r_wait       <= '0;
                  r_dmem_req   <= 1'b1;
                  r_dmem_we    <= mem_write;
                  r_dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  r_dmem_be    <= w_be;
                  r_dmem_wdata <= w_wdata;
                  r_is_load    <= mem_read;
                  r_size       <= inst_size;
                  r_unsigned   <= load_unsigned;
                  r_lane       <= addr[1:0];
                  r_rd         <= rd;
               end
            end
         end else begin
            if (dmem_ack) begin
               r_state    <= S_IDLE;
               r_dmem_req <= 1'b0;
               if (r_is_load) begin
                  r_wb_valid <= 1'b1;
                  r_wb_rd    <= r_rd;
                  r_wb_data  <= load_extract(dmem_rdata, r_size, r_lane, r_unsigned);
               end
            end else if (w_timeout) begin
               r_state    <= S_IDLE;
               r_dmem_req <= 1'b0;
               r_err      <= 1'b1;
            end else begin
               r_wait <= r_wait + 1'b1;
            end
         end
      end
   end

   assign wb_valid   = r_wb_valid;
   assign wb_rd      = r_wb_rd;
   assign wb_data    = r_wb_data;
   assign access_err = r_err;
   assign dmem_req   = r_dmem_req;
   assign dmem_we    = r_dmem_we;
   assign dmem_addr  = r_dmem_addr;
   assign dmem_be    = r_dmem_be;
   assign dmem_wdata = r_dmem_wdata;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_lsu
//
// Self-checking bench for mem_stage_lsu. It runs a table of directed
// load/store vectors, plus hand-written sequences for reset, non-memory
// instructions, timeout and reset during BUSY. The DUT uses MAX_WAIT=4.
// Expectations for the misaligned word load follow MISALIGN_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_mem_stage_lsu;

   logic        clk;
   logic        reset;
   logic        ex_valid;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  inst_size;
   logic        load_unsigned;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [4:0]  rd;
   logic        stall;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        access_err;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   int n_checks = 0;
   int n_errors = 0;

   mem_stage_lsu #(.ADDR_W(32), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset), .ex_valid(ex_valid), .mem_read(mem_read),
      .mem_write(mem_write), .inst_size(inst_size), .load_unsigned(load_unsigned),
      .addr(addr), .store_data(store_data), .rd(rd), .stall(stall),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .access_err(access_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        rd_en;
      logic        wr_en;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] sdata;
      logic [31:0] rdata;
      logic [4:0]  rd;
      int          delay;
      logic        exp_err;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_daddr;
      logic [31:0] exp_wb;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic r, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                      input logic [4:0] d, input int dly, input logic e, input logic [3:0] be,
                      input logic [31:0] wd, input logic [31:0] da, input logic [31:0] wb);
      vec_t v;
      v.rd_en = r; v.wr_en = w; v.size = sz; v.uns = u; v.addr = a; v.sdata = sd;
      v.rdata = rdat; v.rd = d; v.delay = dly; v.exp_err = e; v.exp_be = be;
      v.exp_wdata = wd; v.exp_daddr = da; v.exp_wb = wb;
      vq.push_back(v);
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; inst_size = 2'b00;
      load_unsigned = 1'b0; addr = 32'h0; store_data = 32'h0; rd = 5'd0;
      dmem_ack = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int stall_cnt;
      @(posedge clk); #1;
      ex_valid = 1'b1; mem_read = v.rd_en; mem_write = v.wr_en; inst_size = v.size;
      load_unsigned = v.uns; addr = v.addr; store_data = v.sdata; rd = v.rd;
      dmem_ack = 1'b0; dmem_rdata = v.rdata;
      @(negedge clk);
      check($sformatf("v%0d accept req", idx), {31'b0, dmem_req}, 32'd0);
      check($sformatf("v%0d accept stall", idx), {31'b0, stall}, {31'b0, ~v.exp_err});
      stall_cnt = int'(stall);
      if (v.exp_err) begin
         @(posedge clk); #1;
         idle_inputs();
         @(negedge clk);
         check($sformatf("v%0d err", idx), {31'b0, access_err}, 32'd1);
         check($sformatf("v%0d err req", idx), {31'b0, dmem_req}, 32'd0);
         check($sformatf("v%0d err wb", idx), {31'b0, wb_valid}, 32'd0);
         @(posedge clk); #1;
         @(negedge clk);
         check($sformatf("v%0d err pulse", idx), {31'b0, access_err}, 32'd0);
      end else begin
         for (int k = 0; k <= v.delay; k++) begin
            @(posedge clk); #1;
            dmem_ack = (k == v.delay);
            @(negedge clk);
            check($sformatf("v%0d busy%0d req", idx, k), {31'b0, dmem_req}, 32'd1);
            check($sformatf("v%0d busy%0d addr", idx, k), dmem_addr, v.exp_daddr);
            check($sformatf("v%0d busy%0d be", idx, k), {28'b0, dmem_be}, {28'b0, v.exp_be});
            if (k == 0) begin
               check($sformatf("v%0d we", idx), {31'b0, dmem_we}, {31'b0, v.wr_en});
               if (v.wr_en)
                  check($sformatf("v%0d wdata", idx), dmem_wdata, v.exp_wdata);
            end
            stall_cnt += int'(stall);
         end
         @(posedge clk); #1;
         idle_inputs();
         @(negedge clk);
         check($sformatf("v%0d stall cycles", idx), stall_cnt, v.delay + 1);
         check($sformatf("v%0d done req", idx), {31'b0, dmem_req}, 32'd0);
         check($sformatf("v%0d wb_valid", idx), {31'b0, wb_valid}, {31'b0, v.rd_en});
         check($sformatf("v%0d done err", idx), {31'b0, access_err}, 32'd0);
         if (v.rd_en) begin
            check($sformatf("v%0d wb_data", idx), wb_data, v.exp_wb);
            check($sformatf("v%0d wb_rd", idx), {27'b0, wb_rd}, {27'b0, v.rd});
         end
         @(posedge clk); #1;
         @(negedge clk);
         check($sformatf("v%0d wb pulse", idx), {31'b0, wb_valid}, 32'd0);
      end
   endtask

   initial begin
      idle_inputs();
      dmem_rdata = 32'h0;
      reset = 1'b1;

      //   rd wr size uns addr        sdata         rdata         rd  dly err be       wdata         daddr         wb
      add(0, 1, 2'b10, 0, 32'h104, 32'hDEADBEEF, 32'h0,        5'd0, 3, 0, 4'b1111, 32'hDEADBEEF, 32'h104, 32'h0);
      add(1, 0, 2'b00, 0, 32'h203, 32'h0,        32'h80FF1234, 5'd5, 0, 0, 4'b1000, 32'h0,        32'h200, 32'hFFFFFF80);
      add(1, 0, 2'b00, 1, 32'h203, 32'h0,        32'h80FF1234, 5'd5, 0, 0, 4'b1000, 32'h0,        32'h200, 32'h00000080);
      add(1, 0, 2'b01, 0, 32'h102, 32'h0,        32'h8001ABCD, 5'd7, 1, 0, 4'b1100, 32'h0,        32'h100, 32'hFFFF8001);
      add(0, 1, 2'b01, 0, 32'h102, 32'h1234,     32'h0,        5'd0, 0, 0, 4'b1100, 32'h12341234, 32'h100, 32'h0);
`ifdef MISALIGN_TRAP_EN
      add(1, 0, 2'b10, 0, 32'h101, 32'h0,        32'hCAFEF00D, 5'd9, 0, 1, 4'b0000, 32'h0,        32'h0,   32'h0);
`else
      add(1, 0, 2'b10, 0, 32'h101, 32'h0,        32'hCAFEF00D, 5'd9, 0, 0, 4'b1111, 32'h0,        32'h100, 32'hCAFEF00D);
`endif
      add(1, 0, 2'b11, 0, 32'h100, 32'h0,        32'h0,        5'd3, 0, 1, 4'b0000, 32'h0,        32'h0,   32'h0);
      add(1, 1, 2'b10, 0, 32'h100, 32'h0,        32'h0,        5'd3, 0, 1, 4'b0000, 32'h0,        32'h0,   32'h0);
      add(0, 1, 2'b00, 0, 32'h001, 32'h000000A5, 32'h0,        5'd0, 1, 0, 4'b0010, 32'hA5A5A5A5, 32'h000, 32'h0);
      add(1, 0, 2'b01, 1, 32'h200, 32'h0,        32'h1234F00F, 5'd31,2, 0, 4'b0011, 32'h0,        32'h200, 32'h0000F00F);
      add(1, 0, 2'b00, 0, 32'h201, 32'h0,        32'h12345678, 5'd1, 0, 0, 4'b0010, 32'h0,        32'h200, 32'h00000056);
      add(1, 0, 2'b01, 0, 32'h100, 32'h0,        32'hFFFF7FFF, 5'd2, 0, 0, 4'b0011, 32'h0,        32'h100, 32'h00007FFF);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst stall", {31'b0, stall}, 32'd0);
      check("rst wb_valid", {31'b0, wb_valid}, 32'd0);
      check("rst err", {31'b0, access_err}, 32'd0);
      check("rst req", {31'b0, dmem_req}, 32'd0);
      check("rst we", {31'b0, dmem_we}, 32'd0);
      check("rst be", {28'b0, dmem_be}, 32'd0);
      check("rst addr", dmem_addr, 32'd0);
      check("rst wdata", dmem_wdata, 32'd0);
      check("rst wb_data", wb_data, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Table vectors
      for (int i = 0; i < vq.size(); i++)
         run_vec(i, vq[i]);

      // Non-memory instruction bypasses the unit
      @(posedge clk); #1;
      ex_valid = 1'b1; inst_size = 2'b10; addr = 32'h400; rd = 5'd4;
      @(negedge clk);
      check("nonmem stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("nonmem req", {31'b0, dmem_req}, 32'd0);
      check("nonmem wb", {31'b0, wb_valid}, 32'd0);
      check("nonmem err", {31'b0, access_err}, 32'd0);

      // Timeout: MAX_WAIT=4, ack never arrives
      @(posedge clk); #1;
      ex_valid = 1'b1; mem_read = 1'b1; inst_size = 2'b10; addr = 32'h300; rd = 5'd6;
      dmem_rdata = 32'h55AA55AA;
      @(negedge clk);
      check("to accept stall", {31'b0, stall}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check($sformatf("to busy%0d req", k), {31'b0, dmem_req}, 32'd1);
         check($sformatf("to busy%0d err", k), {31'b0, access_err}, 32'd0);
         if (k < 3)
            check($sformatf("to busy%0d stall", k), {31'b0, stall}, 32'd1);
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("to err", {31'b0, access_err}, 32'd1);
      check("to req", {31'b0, dmem_req}, 32'd0);
      check("to stall", {31'b0, stall}, 32'd0);
      check("to wb", {31'b0, wb_valid}, 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b1;
      @(negedge clk);
      check("to err pulse", {31'b0, access_err}, 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      check("to stray ack wb", {31'b0, wb_valid}, 32'd0);
      check("to stray ack req", {31'b0, dmem_req}, 32'd0);

      // Reset in the 2nd BUSY cycle of a load
      @(posedge clk); #1;
      ex_valid = 1'b1; mem_read = 1'b1; inst_size = 2'b00; addr = 32'h203; rd = 5'd8;
      dmem_rdata = 32'h80FF1234;
      @(posedge clk); #1;
      @(negedge clk);
      check("rb busy1 req", {31'b0, dmem_req}, 32'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      idle_inputs();
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rb req", {31'b0, dmem_req}, 32'd0);
      check("rb stall", {31'b0, stall}, 32'd0);
      check("rb wb", {31'b0, wb_valid}, 32'd0);
      @(posedge clk); #1;
      dmem_ack = 1'b1;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(negedge clk);
      check("rb stray wb", {31'b0, wb_valid}, 32'd0);
      check("rb stray err", {31'b0, access_err}, 32'd0);
      check("rb stray req", {31'b0, dmem_req}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
